gpr_wb_arbiter: RTL and testbench

Write-back arbiter sitting directly upstream of the GPR file. It merges results from the ALU, load/store unit (LSU) and multiply/divide unit (MDU) onto the GPR's two write ports (wr0/waddr0/wd0, wr1/waddr1/wd1). It keeps the GPR's combinational read bypass coherent, because that bypass compares addresses without qualifying on write enable. It also guarantees that the two ports never write the same register in the same cycle.

---
 rtl/gpr_wb_arbiter_if.sv | 40 ++++
 rtl/gpr_wb_arbiter.sv | 106 ++++++++++
 tb/tb_gpr_wb_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/gpr_wb_arbiter_if.sv
// Write-back bus between the ALU/LSU/MDU producers, the arbiter and the GPR write ports.
interface gpr_wb_arbiter_if #(
  parameter int unsigned GPR_DEPTH = 5,
  parameter int unsigned GPR_WIDTH = 32
);
  logic                 alu_valid;
  logic [GPR_DEPTH-1:0] alu_waddr;
  logic [GPR_WIDTH-1:0] alu_wd;
  logic                 lsu_valid;
  logic                 lsu_ready;
  logic [GPR_DEPTH-1:0] lsu_waddr;
  logic [GPR_WIDTH-1:0] lsu_wd;
  logic                 mdu_valid;
  logic                 mdu_ready;
  logic [GPR_DEPTH-1:0] mdu_waddr;
  logic [GPR_WIDTH-1:0] mdu_wd;
  logic                 wr0;
  logic [GPR_DEPTH-1:0] waddr0;
  logic [GPR_WIDTH-1:0] wd0;
  logic                 wr1;
  logic [GPR_DEPTH-1:0] waddr1;
  logic [GPR_WIDTH-1:0] wd1;
  logic                 busy;

  modport slave (
    input  alu_valid, alu_waddr, alu_wd,
    input  lsu_valid, lsu_waddr, lsu_wd,
    input  mdu_valid, mdu_waddr, mdu_wd,
    output lsu_ready, mdu_ready,
    output wr0, waddr0, wd0, wr1, waddr1, wd1, busy
  );

  modport master (
    output alu_valid, alu_waddr, alu_wd,
    output lsu_valid, lsu_waddr, lsu_wd,
    output mdu_valid, mdu_waddr, mdu_wd,
    input  lsu_ready, mdu_ready,
    input  wr0, waddr0, wd0, wr1, waddr1, wd1, busy
  );
endinterface

// File: rtl/gpr_wb_arbiter.sv
// GPR write-back arbiter: ALU on port 0, queued LSU/MDU results on port 1,
// with idle-port hold so the unqualified GPR read bypass stays coherent.
module gpr_wb_arbiter #(
  parameter int unsigned GPR_DEPTH = 5,
  parameter int unsigned GPR_WIDTH = 32,
  parameter int unsigned Q_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  gpr_wb_arbiter_if.slave bus
);
  localparam int unsigned PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CW = $clog2(Q_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(Q_DEPTH);
  localparam logic [CW-1:0] MDU_CNT  = CW'(Q_DEPTH - 1);

  typedef struct packed {
    logic [GPR_DEPTH-1:0] addr;
    logic [GPR_WIDTH-1:0] data;
  } entry_t;

  entry_t               q_mem [Q_DEPTH];
  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count;

  logic                 wr0_q, wr1_q;
  logic [GPR_DEPTH-1:0] waddr0_q, waddr1_q;
  logic [GPR_WIDTH-1:0] wd0_q, wd1_q;

  logic   lsu_rdy, mdu_rdy;
  logic   lsu_push, mdu_push;
  logic   deq, drop, issue;
  entry_t hd;

  // Ready depends only on the registered count, never on any valid.
  assign lsu_rdy = (count < FULL_CNT);
  assign mdu_rdy = (count < MDU_CNT);

  always_comb begin
    lsu_push = bus.lsu_valid && lsu_rdy;
    mdu_push = bus.mdu_valid && mdu_rdy;
    hd       = q_mem[head];
    deq      = (count != '0);
    drop     = deq && bus.alu_valid && (hd.addr == bus.alu_waddr);
    issue    = deq && !drop;
  end

  // LSU takes the first free slot when both producers transfer together.
  always_ff @(posedge clk) begin
    if (lsu_push)
      q_mem[tail] <= '{addr: bus.lsu_waddr, data: bus.lsu_wd};
    if (mdu_push)
      q_mem[lsu_push ? tail + PW'(1) : tail] <= '{addr: bus.mdu_waddr, data: bus.mdu_wd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(lsu_push) + PW'(mdu_push);
      count <= count + CW'(lsu_push) + CW'(mdu_push) - CW'(deq);
    end
  end

  // An idle port keeps its address; if the other port writes that address,
  // the idle port's data follows so the bypass matches the stored value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0_q    <= 1'b0;
      waddr0_q <= '0;
      wd0_q    <= '0;
      wr1_q    <= 1'b0;
      waddr1_q <= '0;
      wd1_q    <= '0;
    end else begin
      wr0_q <= bus.alu_valid;
      wr1_q <= issue;
      if (bus.alu_valid) begin
        waddr0_q <= bus.alu_waddr;
        wd0_q    <= bus.alu_wd;
      end else if (issue && (hd.addr == waddr0_q)) begin
        wd0_q    <= hd.data;
      end
      if (issue) begin
        waddr1_q <= hd.addr;
        wd1_q    <= hd.data;
      end else if (bus.alu_valid && (bus.alu_waddr == waddr1_q)) begin
        wd1_q    <= bus.alu_wd;
      end
    end
  end

  assign bus.lsu_ready = lsu_rdy;
  assign bus.mdu_ready = mdu_rdy;
  assign bus.wr0       = wr0_q;
  assign bus.waddr0    = waddr0_q;
  assign bus.wd0       = wd0_q;
  assign bus.wr1       = wr1_q;
  assign bus.waddr1    = waddr1_q;
  assign bus.wd1       = wd1_q;
  assign bus.busy      = (count != '0) || wr0_q || wr1_q;
endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: transaction-level queue scoreboard
// plus directed cases for latency, ordering, supersede, hold and reset.
module tb_gpr_wb_arbiter;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned QD = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  logic clk;
  logic rst_n;

  gpr_wb_arbiter_if #(.GPR_DEPTH(AW), .GPR_WIDTH(DW)) bus ();

  gpr_wb_arbiter #(.GPR_DEPTH(AW), .GPR_WIDTH(DW), .Q_DEPTH(QD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  ent_t          sb_q[$];
  logic          e_wr0, e_wr1;
  logic [AW-1:0] e_a0, e_a1;
  logic [DW-1:0] e_d0, e_d1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
                       input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md);
    bus.alu_valid = av; bus.alu_waddr = aa; bus.alu_wd = ad;
    bus.lsu_valid = lv; bus.lsu_waddr = la; bus.lsu_wd = ld;
    bus.mdu_valid = mv; bus.mdu_waddr = ma; bus.mdu_wd = md;
  endtask

  task automatic idle_in();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    e_wr0 = 1'b0; e_a0 = '0; e_d0 = '0;
    e_wr1 = 1'b0; e_a1 = '0; e_d1 = '0;
  endtask

  // One clock: predict from current inputs, let the edge happen, compare.
  task automatic step();
    ent_t          h;
    logic          lr, mr, nwr0, nwr1;
    logic [AW-1:0] na0, na1;
    logic [DW-1:0] nd0, nd1;
    lr = (sb_q.size() < QD);
    mr = (sb_q.size() < QD - 1);
    check_eq("lsu_ready", 64'(bus.lsu_ready), 64'(lr));
    check_eq("mdu_ready", 64'(bus.mdu_ready), 64'(mr));
    nwr1 = 1'b0; na1 = e_a1; nd1 = e_d1;
    if (sb_q.size() > 0) begin
      h = sb_q.pop_front();
      if (!(bus.alu_valid && h.addr == bus.alu_waddr)) begin
        nwr1 = 1'b1; na1 = h.addr; nd1 = h.data;
      end
    end
    nwr0 = bus.alu_valid; na0 = e_a0; nd0 = e_d0;
    if (nwr0) begin
      na0 = bus.alu_waddr; nd0 = bus.alu_wd;
    end else if (nwr1 && na1 == e_a0) begin
      nd0 = nd1;
    end
    if (!nwr1 && nwr0 && bus.alu_waddr == e_a1) nd1 = bus.alu_wd;
    if (bus.lsu_valid && lr) sb_q.push_back('{bus.lsu_waddr, bus.lsu_wd});
    if (bus.mdu_valid && mr) sb_q.push_back('{bus.mdu_waddr, bus.mdu_wd});
    @(posedge clk);
    #1;
    e_wr0 = nwr0; e_a0 = na0; e_d0 = nd0;
    e_wr1 = nwr1; e_a1 = na1; e_d1 = nd1;
    check_eq("wr0",    64'(bus.wr0),    64'(e_wr0));
    check_eq("waddr0", 64'(bus.waddr0), 64'(e_a0));
    check_eq("wd0",    64'(bus.wd0),    64'(e_d0));
    check_eq("wr1",    64'(bus.wr1),    64'(e_wr1));
    check_eq("waddr1", 64'(bus.waddr1), 64'(e_a1));
    check_eq("wd1",    64'(bus.wd1),    64'(e_d1));
    check_eq("busy",   64'(bus.busy),   64'(sb_q.size() != 0 || nwr0 || nwr1));
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_wr0"},    64'(bus.wr0),    64'(0));
    check_eq({tag, "_wr1"},    64'(bus.wr1),    64'(0));
    check_eq({tag, "_waddr0"}, 64'(bus.waddr0), 64'(0));
    check_eq({tag, "_waddr1"}, 64'(bus.waddr1), 64'(0));
    check_eq({tag, "_wd0"},    64'(bus.wd0),    64'(0));
    check_eq({tag, "_wd1"},    64'(bus.wd1),    64'(0));
    check_eq({tag, "_busy"},   64'(bus.busy),   64'(0));
    check_eq({tag, "_lsu_rdy"}, 64'(bus.lsu_ready), 64'(1));
    check_eq({tag, "_mdu_rdy"}, 64'(bus.mdu_ready), 64'(1));
  endtask

  task automatic drain();
    idle_in();
    for (int i = 0; i < 6; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_in();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    #2 rst_n = 1'b1;

    // ALU path latency and hold
    drive(1'b1, 5'd3, 32'h11, 1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check_eq("alu_wr0", 64'(bus.wr0), 64'(1));
    check_eq("alu_waddr0", 64'(bus.waddr0), 64'(3));
    check_eq("alu_wd0", 64'(bus.wd0), 64'h11);
    idle_in();
    step();
    check_eq("alu_hold_wr0", 64'(bus.wr0), 64'(0));
    check_eq("alu_hold_waddr0", 64'(bus.waddr0), 64'(3));
    check_eq("alu_hold_wd0", 64'(bus.wd0), 64'h11);

    // Dual enqueue: LSU ahead of MDU, first write two cycles later
    drain();
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'hAA, 1'b1, 5'd6, 32'hBB);
    step();
    check_eq("dual_n1_wr1", 64'(bus.wr1), 64'(0));
    idle_in();
    step();
    check_eq("dual_n2_wr1", 64'(bus.wr1), 64'(1));
    check_eq("dual_n2_waddr1", 64'(bus.waddr1), 64'(5));
    step();
    check_eq("dual_n3_waddr1", 64'(bus.waddr1), 64'(6));
    check_eq("dual_n3_wd1", 64'(bus.wd1), 64'hBB);

    // Supersede: ALU to same register discards the queue head
    drain();
    drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h1, 1'b0, '0, '0);
    step();
    drive(1'b1, 5'd7, 32'h2, 1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check_eq("sup_wr0", 64'(bus.wr0), 64'(1));
    check_eq("sup_wd0", 64'(bus.wd0), 64'h2);
    check_eq("sup_wr1", 64'(bus.wr1), 64'(0));
    check_eq("sup_busy", 64'(bus.busy), 64'(1));
    idle_in();
    step();
    check_eq("sup_empty_busy", 64'(bus.busy), 64'(0));

    // Hold coherence on idle port 1
    drain();
    drive(1'b0, '0, '0, 1'b1, 5'd4, 32'h10, 1'b0, '0, '0);
    step();
    idle_in();
    step();
    drive(1'b1, 5'd4, 32'h20, 1'b0, '0, '0, 1'b0, '0, '0);
    step();
    check_eq("hold_wr1", 64'(bus.wr1), 64'(0));
    check_eq("hold_waddr1", 64'(bus.waddr1), 64'(4));
    check_eq("hold_wd1", 64'(bus.wd1), 64'h20);

    // Backpressure: both producers every cycle, distinct addresses
    drain();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, '0, '0, 1'b1, AW'(2 * i), DW'(32'h100 + i), 1'b1, AW'(2 * i + 1), DW'(32'h200 + i));
      step();
    end
    drain();

    // Random traffic on a narrow address range to hit supersede and hold
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
      step();
    end

    // Reset mid-traffic: immediate clear, no spurious writes after release
    drive(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h98, 1'b1, 5'd11, 32'h97);
    step();
    step();
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    #1;
    check_reset_state("midrst_hold");
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
